core_output_merger: RTL and testbench

- Downstream of the multicore array. Collects per-core result samples (io_out/out_en pairs) from NCH cores and serializes them into one ordered output stream with a valid/ready handshake.
- Replaces direct per-core file/port writes with a single merged sink for the host/DMA side.
- Buffers each core in a small FIFO, arbitrates round-robin, and reports overflow per core.

---
 rtl/core_output_merger_if.sv | 25 ++
 rtl/core_output_merger.sv | 143 ++++++++++++++
 tb/tb_core_output_merger.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_output_merger_if.sv
// Merged output stream of core_output_merger: sample, source channel, valid/ready.
// master drives m_data/m_chan/m_valid and samples m_ready; slave is the sink side.
interface core_output_merger_if #(
    parameter int DW = 31,
    parameter int CW = 5
);
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_chan;
    logic          m_valid;
    logic          m_ready;

    modport master (
        output m_data,
        output m_chan,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_chan,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/core_output_merger.sv
// Collects per-core samples into per-channel FIFOs and serializes them round-robin
// into one valid/ready stream. Ports: clk, rst (sync, active-high), io_out/out_en
// (per-core sample + 4-bit enable, strobe when field == 1), stream (master modport:
// m_data/m_chan/m_valid out, m_ready in), clr_ovf in, ovf (sticky per channel) and
// drop_cnt (saturating total drops) out.
module core_output_merger #(
    parameter int NCH   = 23,
    parameter int DW    = 31,
    parameter int DEPTH = 4,
    parameter int CW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*DW-1:0]     io_out,
    input  logic [NCH*4-1:0]      out_en,
    core_output_merger_if.master  stream,
    input  logic                  clr_ovf,
    output logic [NCH-1:0]        ovf,
    output logic [15:0]           drop_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;
    localparam int SW = 6;
    localparam logic [NW-1:0] FULL = NW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    logic [DW-1:0] mem    [NCH][DEPTH];
    logic [AW-1:0] rd_ptr [NCH];
    logic [AW-1:0] wr_ptr [NCH];
    logic [NW-1:0] cnt    [NCH];

    logic [CW-1:0]  rr;
    logic [CW-1:0]  gnt;
    logic           gnt_vld;
    logic           load;
    logic [NCH-1:0] push_req;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] drop;
    logic [SW-1:0]  n_drop;
    logic [15:0]    drop_base;
    logic [16:0]    drop_sum;

    logic [DW-1:0]  data_q;
    logic [CW-1:0]  chan_q;
    logic           valid_q;

    assign stream.m_data  = data_q;
    assign stream.m_chan  = chan_q;
    assign stream.m_valid = valid_q;

    // First non-empty channel strictly after rr, wrapping NCH-1 -> 0.
    // Occupancy is the registered count, so this cycle's pushes are not eligible.
    always_comb begin
        logic [CW:0]   s;
        logic [CW-1:0] idx;
        gnt_vld = 1'b0;
        gnt     = '0;
        s       = '0;
        idx     = '0;
        for (int k = 1; k <= NCH; k++) begin
            s = {1'b0, rr} + (CW+1)'(k);
            if (s >= (CW+1)'(NCH))
                s = s - (CW+1)'(NCH);
            idx = s[CW-1:0];
            if (!gnt_vld && cnt[idx] != '0) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    assign load = gnt_vld && (!valid_q || stream.m_ready);

    // A full FIFO still accepts a push when it is popped the same cycle.
    always_comb begin
        push_req = '0;
        push     = '0;
        pop      = '0;
        drop     = '0;
        n_drop   = '0;
        for (int i = 0; i < NCH; i++) begin
            push_req[i] = (out_en[i*4 +: 4] == 4'd1);
            pop[i]      = load && (gnt == CW'(i));
            push[i]     = push_req[i] && (cnt[i] != FULL || pop[i]);
            drop[i]     = push_req[i] && (cnt[i] == FULL) && !pop[i];
            n_drop      = n_drop + {{(SW-1){1'b0}}, drop[i]};
        end
    end

    // A clear coincident with drops leaves exactly this cycle's drops.
    assign drop_base = clr_ovf ? 16'd0 : drop_cnt;
    assign drop_sum  = {1'b0, drop_base} + 17'(n_drop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= io_out[i*DW +: DW];
                    wr_ptr[i]         <= wr_ptr[i] + 1'b1;
                end
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (pop[i] && !push[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            rr      <= LAST;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= mem[gnt][rd_ptr[gnt]];
            chan_q  <= gnt;
            rr      <= gnt;
        end else if (stream.m_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= '0;
            drop_cnt <= '0;
        end else begin
            ovf      <= (clr_ovf ? '0 : ovf) | drop;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule

// File: tb/tb_core_output_merger.sv
// Self-checking bench for core_output_merger: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_core_output_merger;
    localparam int NCH   = 23;
    localparam int DW    = 31;
    localparam int DEPTH = 4;
    localparam int CW    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] io_out;
    logic [NCH*4-1:0]  out_en;
    logic              clr_ovf;
    logic [NCH-1:0]    ovf;
    logic [15:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    core_output_merger_if #(.DW(DW), .CW(CW)) m_if ();

    core_output_merger #(
        .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CW(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_out   (io_out),
        .out_en   (out_en),
        .stream   (m_if),
        .clr_ovf  (clr_ovf),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: one queue per channel plus the output word.
    logic [DW-1:0]  q_m [NCH][$];
    int             rr_m;
    logic           mv_m;
    logic [DW-1:0]  md_m;
    int             mc_m;
    logic [NCH-1:0] ovf_m;
    int             dc_m;

    function automatic logic [DW-1:0] sv(input int x);
        return x[DW-1:0];
    endfunction

    task automatic model_step();
        int g;
        int c;
        int n;
        logic [NCH-1:0] mask;
        if (rst) begin
            for (int i = 0; i < NCH; i++) q_m[i].delete();
            rr_m  = NCH - 1;
            mv_m  = 1'b0;
            md_m  = '0;
            mc_m  = 0;
            ovf_m = '0;
            dc_m  = 0;
            return;
        end
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
            c = (rr_m + k) % NCH;
            if (g < 0 && q_m[c].size() > 0) g = c;
        end
        if (g >= 0 && (!mv_m || m_if.m_ready)) begin
            md_m = q_m[g].pop_front();
            mc_m = g;
            mv_m = 1'b1;
            rr_m = g;
        end else if (m_if.m_ready) begin
            mv_m = 1'b0;
        end
        n    = 0;
        mask = '0;
        for (int i = 0; i < NCH; i++) begin
            if (out_en[i*4 +: 4] == 4'd1) begin
                if (q_m[i].size() < DEPTH) begin
                    q_m[i].push_back(io_out[i*DW +: DW]);
                end else begin
                    n++;
                    mask[i] = 1'b1;
                end
            end
        end
        if (clr_ovf) begin
            ovf_m = mask;
            dc_m  = n;
        end else begin
            ovf_m = ovf_m | mask;
            dc_m  = dc_m + n;
        end
        if (dc_m > 65535) dc_m = 65535;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        out_en = '0;
    endtask

    task automatic strobe(input int ch, input logic [DW-1:0] d);
        io_out[ch*DW +: DW] = d;
        out_en[ch*4 +: 4]   = 4'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_if.m_ready = 1'b0;
        out_en = {NCH{4'd1}};
        for (int i = 0; i < NCH; i++) io_out[i*DW +: DW] = DW'($urandom);
        tick();
        tick();
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", m_if.m_valid);
        end
        checks++;
        if (ovf !== '0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_ovf got ovf=%h cnt=%h want 0", ovf, drop_cnt);
        end
        checks++;
        if (m_if.m_data !== '0 || m_if.m_chan !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d want 0/0", m_if.m_data, m_if.m_chan);
        end
        rst = 1'b0;
        idle();
        strobe(5, sv(-1234));
        tick();
        idle();
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_latency_early got %b want 0", m_if.m_valid);
        end
        tick();
        checks++;
        if (m_if.m_valid !== 1'b1 || m_if.m_data !== sv(-1234) || m_if.m_chan !== CW'(5)) begin
            errors++;
            $display("FAIL first_word got v=%b d=%h c=%0d want 1/%h/5",
                     m_if.m_valid, m_if.m_data, m_if.m_chan, sv(-1234));
        end
        m_if.m_ready = 1'b1;
        tick();
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_drain got %b want 0", m_if.m_valid);
        end
    endtask

    task automatic test_burst();
        int ch [3];
        int dv [3];
        ch = '{0, 7, 22};
        dv = '{10, -20, 30};
        do_reset();
        m_if.m_ready = 1'b1;
        for (int j = 0; j < 3; j++) strobe(ch[j], sv(dv[j]));
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_chan !== CW'(ch[j]) || m_if.m_data !== sv(dv[j])) begin
                errors++;
                $display("FAIL burst_%0d got v=%b c=%0d d=%h want 1/%0d/%h",
                         j, m_if.m_valid, m_if.m_chan, m_if.m_data, ch[j], sv(dv[j]));
            end
        end
        tick();
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_end got %b want 0", m_if.m_valid);
        end
    endtask

    task automatic test_round_robin();
        int ec;
        int ed;
        do_reset();
        m_if.m_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            strobe(1, sv(100 + r));
            strobe(2, sv(200 + r));
            tick();
        end
        idle();
        m_if.m_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            ec = (j % 2 == 0) ? 1 : 2;
            ed = ec * 100 + j / 2;
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_chan !== CW'(ec) || m_if.m_data !== sv(ed)) begin
                errors++;
                $display("FAIL rr_%0d got v=%b c=%0d d=%0d want 1/%0d/%0d",
                         j, m_if.m_valid, m_if.m_chan, m_if.m_data, ec, ed);
            end
            tick();
        end
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_end got %b want 0", m_if.m_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_if.m_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            strobe(3, sv(v));
            tick();
        end
        idle();
        checks++;
        if (m_if.m_valid !== 1'b1 || m_if.m_data !== sv(1)) begin
            errors++;
            $display("FAIL bp_hold got v=%b d=%0d want 1/1", m_if.m_valid, m_if.m_data);
        end
        checks++;
        if (ovf !== NCH'(1 << 3) || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_ovf got ovf=%h cnt=%0d want %h/1", ovf, drop_cnt, NCH'(1 << 3));
        end
        m_if.m_ready = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== sv(j) || m_if.m_chan !== CW'(3)) begin
                errors++;
                $display("FAIL bp_word_%0d got v=%b d=%0d c=%0d want 1/%0d/3",
                         j, m_if.m_valid, m_if.m_data, m_if.m_chan, j);
            end
            tick();
        end
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end got %b want 0", m_if.m_valid);
        end
    endtask

    task automatic test_non_strobe();
        do_reset();
        m_if.m_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            strobe(4, sv(40 + j));
            tick();
        end
        io_out[4*DW +: DW] = sv(99);
        out_en[4*4 +: 4]   = 4'd2;
        tick();
        out_en[4*4 +: 4]   = 4'd15;
        tick();
        idle();
        checks++;
        if (drop_cnt !== 16'd0 || ovf !== '0) begin
            errors++;
            $display("FAIL nonstrobe_drop got cnt=%0d ovf=%h want 0/0", drop_cnt, ovf);
        end
        m_if.m_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== sv(40 + j)) begin
                errors++;
                $display("FAIL nonstrobe_word_%0d got v=%b d=%0d want 1/%0d",
                         j, m_if.m_valid, m_if.m_data, 40 + j);
            end
            tick();
        end
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL nonstrobe_end got %b want 0", m_if.m_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        m_if.m_ready = 1'b0;
        out_en = {NCH{4'd1}};
        for (int c = 0; c < 2900; c++) begin
            io_out = {NCH{DW'($urandom)}};
            tick();
        end
        idle();
        checks++;
        if (drop_cnt !== 16'hFFFF || ovf !== {NCH{1'b1}}) begin
            errors++;
            $display("FAIL sat got cnt=%h ovf=%h want ffff/all", drop_cnt, ovf);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (drop_cnt !== 16'd0 || ovf !== '0) begin
            errors++;
            $display("FAIL clr got cnt=%h ovf=%h want 0/0", drop_cnt, ovf);
        end
        clr_ovf = 1'b1;
        strobe(9, sv(555));
        tick();
        clr_ovf = 1'b0;
        idle();
        checks++;
        if (drop_cnt !== 16'd1 || ovf !== NCH'(1 << 9)) begin
            errors++;
            $display("FAIL clr_drop got cnt=%h ovf=%h want 1/%h", drop_cnt, ovf, NCH'(1 << 9));
        end
    endtask

    task automatic test_random();
        int rate;
        int r;
        do_reset();
        rate = 5;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rate = $urandom_range(1, 12);
            for (int i = 0; i < NCH; i++) begin
                r = $urandom_range(0, 99);
                io_out[i*DW +: DW] = DW'($urandom);
                if (r < rate)
                    out_en[i*4 +: 4] = 4'd1;
                else if (r < rate + 3)
                    out_en[i*4 +: 4] = 4'($urandom_range(0, 15));
                else
                    out_en[i*4 +: 4] = 4'd0;
            end
            m_if.m_ready = ($urandom_range(0, 9) < 6);
            clr_ovf      = ($urandom_range(0, 99) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            tick();
            checks++;
            if (m_if.m_valid !== mv_m) begin
                errors++;
                $display("FAIL rand_valid c=%0d got %b want %b", c, m_if.m_valid, mv_m);
            end
            if (mv_m) begin
                checks++;
                if (m_if.m_data !== md_m || m_if.m_chan !== CW'(mc_m)) begin
                    errors++;
                    $display("FAIL rand_word c=%0d got %h/%0d want %h/%0d",
                             c, m_if.m_data, m_if.m_chan, md_m, mc_m);
                end
            end
            checks++;
            if (ovf !== ovf_m || drop_cnt !== 16'(dc_m)) begin
                errors++;
                $display("FAIL rand_ovf c=%0d got %h/%0d want %h/%0d",
                         c, ovf, drop_cnt, ovf_m, dc_m);
            end
        end
        rst     = 1'b0;
        clr_ovf = 1'b0;
        idle();
    endtask

    initial begin
        rst          = 1'b1;
        io_out       = '0;
        out_en       = '0;
        clr_ovf      = 1'b0;
        m_if.m_ready = 1'b0;
        test_reset();
        test_burst();
        test_round_robin();
        test_backpressure();
        test_non_strobe();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
